// File: rtl/ap_prod_acc.sv
// Saturating dot-product accumulator for the signed multiplier's product stream.
// A group closes after LEN products or on in_last. Its result is held until out_rdy is seen.
module ap_prod_acc #(
  parameter int PW    = 16,
  parameter int ACC_W = 24,
  parameter int LEN   = 8,
  parameter int CW    = $clog2(LEN+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [PW-1:0]    prod,
  input  logic             in_last,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [ACC_W-1:0] acc_out,
  output logic [CW-1:0]    out_cnt,
  output logic             sat
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [CW-1:0] LAST = CW'(LEN-1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, clamped;
  logic [ACC_W:0]   sum;
  logic [CW-1:0]    cnt;
  logic             sat_r, sat_now, hi, lo, accept, close;

  // One guard bit is enough: a single add can overflow ACC_W by at most one bit.
  assign sum     = {acc[ACC_W-1], acc} + {{(ACC_W+1-PW){prod[PW-1]}}, prod};
  assign hi      = ~sum[ACC_W] &  sum[ACC_W-1];
  assign lo      =  sum[ACC_W] & ~sum[ACC_W-1];
  assign sat_now = hi | lo;
  assign clamped = hi ? {1'b0, {(ACC_W-1){1'b1}}} :
                   lo ? {1'b1, {(ACC_W-1){1'b0}}} : sum[ACC_W-1:0];

  assign accept = in_vld & in_rdy;
  assign close  = (cnt == LAST) | in_last;

  always_comb begin
    state_n = state;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    case (state)
      ACC: begin
        in_rdy = ~clr & ~rst;
        if (accept && close) state_n = HOLD;
      end
      HOLD: begin
        out_vld = 1'b1;
        if (out_rdy) state_n = ACC;
      end
      default: state_n = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ACC;
      acc     <= '0;
      cnt     <= '0;
      sat_r   <= 1'b0;
      acc_out <= '0;
      out_cnt <= '0;
      sat     <= 1'b0;
    end else if (clr) begin
      // Flush wins over both a pending product and a result handshake.
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      sat_r <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        if (close) begin
          acc_out <= clamped;
          out_cnt <= cnt + ONE;
          sat     <= sat_r | sat_now;
          acc     <= '0;
          cnt     <= '0;
          sat_r   <= 1'b0;
        end else begin
          acc   <= clamped;
          cnt   <= cnt + ONE;
          sat_r <= sat_r | sat_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_ap_prod_acc.sv
// Directed bench for ap_prod_acc: a 24b-accumulator instance and a 16b-accumulator instance share one stimulus.
// The 16b instance exercises saturation.
module tb_ap_prod_acc;

  logic               clk = 1'b0;
  logic               rst, clr, in_vld, in_last, out_rdy;
  logic signed [15:0] prod;
  logic               in_rdy, out_vld, sat;
  logic signed [23:0] acc24;
  logic [3:0]         cnt24;
  logic               in_rdy16, out_vld16, sat16;
  logic signed [15:0] acc16;
  logic [3:0]         cnt16;
  int                 errors = 0;
  int                 checks = 0;

  always #5 clk = ~clk;

  ap_prod_acc #(.PW(16), .ACC_W(24), .LEN(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_rdy(in_rdy),
    .prod(prod), .in_last(in_last), .out_vld(out_vld), .out_rdy(out_rdy),
    .acc_out(acc24), .out_cnt(cnt24), .sat(sat)
  );

  ap_prod_acc #(.PW(16), .ACC_W(16), .LEN(8)) dut16 (
    .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_rdy(in_rdy16),
    .prod(prod), .in_last(in_last), .out_vld(out_vld16), .out_rdy(out_rdy),
    .acc_out(acc16), .out_cnt(cnt16), .sat(sat16)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one product for one edge; the caller's state decides whether it is taken.
  task automatic push(input logic signed [15:0] p, input logic last);
    in_vld  = 1'b1;
    prod    = p;
    in_last = last;
    @(posedge clk); #1;
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic result(input string tag, input int a, input int c, input logic s);
    chk({tag, ".vld"}, 32'(out_vld), 1);
    chk({tag, ".acc"}, acc24, a);
    chk({tag, ".cnt"}, 32'(cnt24), c);
    chk({tag, ".sat"}, 32'(sat), 32'(s));
  endtask

  task automatic drain();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_vld = 1'b0; in_last = 1'b0; out_rdy = 1'b0; prod = '0;
    #1;
    chk("rst.in_rdy", 32'(in_rdy), 0);
    chk("rst.out_vld", 32'(out_vld), 0);
    chk("rst.acc", acc24, 0);
    chk("rst.cnt", 32'(cnt24), 0);
    chk("rst.sat", 32'(sat), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;

    // 1: eight +3 back to back
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t1.in_rdy", 32'(in_rdy), 1);
      push(16'sd3, 1'b0);
    end
    result("t1", 24, 8, 1'b0);
    chk("t1.hold_rdy", 32'(in_rdy), 0);
    drain();
    chk("t1.vld_drop", 32'(out_vld), 0);
    chk("t1.rdy_back", 32'(in_rdy), 1);

    // 2: early close
    push(-16'sd5, 1'b0);
    push(16'sd2, 1'b0);
    push(-16'sd7, 1'b1);
    result("t2", -10, 3, 1'b0);
    drain();
    push(16'sd1, 1'b1);
    result("t2.next", 1, 1, 1'b0);
    drain();

    // 3: saturation on the 16b instance, clamp applied per add
    push(16'sd32767, 1'b0);
    push(16'sd32767, 1'b1);
    result("t3.w24", 65534, 2, 1'b0);
    chk("t3.acc16", acc16, 32767);
    chk("t3.sat16", 32'(sat16), 1);
    drain();
    for (int i = 0; i < 8; i++) push(16'sd1, 1'b0);
    chk("t3.acc16_b", acc16, 8);
    chk("t3.sat16_b", 32'(sat16), 0);
    chk("t3.cnt16_b", 32'(cnt16), 8);
    drain();
    push(-16'sd32768, 1'b0);
    push(-16'sd32768, 1'b1);
    chk("t3.neg16", acc16, -32768);
    chk("t3.negsat16", 32'(sat16), 1);
    drain();
    push(16'sd32767, 1'b0);
    push(16'sd32767, 1'b0);
    push(-16'sd32768, 1'b1);
    chk("t3.seq16", acc16, -1);
    chk("t3.seqsat16", 32'(sat16), 1);
    result("t3.seq24", 32766, 3, 1'b0);
    drain();

    // 4: backpressure in HOLD
    out_rdy = 1'b0;
    push(16'sd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; prod = 16'sd100; in_last = 1'b1;
      chk("t4.in_rdy", 32'(in_rdy), 0);
      result("t4.hold", 4, 1, 1'b0);
      @(posedge clk); #1;
    end
    in_vld = 1'b0; in_last = 1'b0;
    out_rdy = 1'b1;
    drain();
    chk("t4.vld_drop", 32'(out_vld), 0);
    chk("t4.rdy_back", 32'(in_rdy), 1);
    push(16'sd2, 1'b1);
    result("t4.next", 2, 1, 1'b0);
    drain();

    // 5: clr mid-group with a product presented, then clr while holding
    for (int i = 0; i < 4; i++) push(16'sd10, 1'b0);
    clr = 1'b1; in_vld = 1'b1; prod = 16'sd50;
    #1;
    chk("t5.clr_rdy", 32'(in_rdy), 0);
    @(posedge clk); #1;
    clr = 1'b0; in_vld = 1'b0;
    chk("t5.clr_vld", 32'(out_vld), 0);
    for (int i = 0; i < 7; i++) push(16'sd7, 1'b0);
    chk("t5.no_early", 32'(out_vld), 0);
    push(16'sd7, 1'b0);
    result("t5.fresh", 56, 8, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("t5.hold_drop", 32'(out_vld), 0);
    push(16'sd1, 1'b1);
    result("t5.after", 1, 1, 1'b0);
    drain();

    // 6: asynchronous reset between edges
    for (int i = 0; i < 3; i++) push(16'sd5, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6.acc", acc24, 0);
    chk("t6.cnt", 32'(cnt24), 0);
    chk("t6.in_rdy", 32'(in_rdy), 0);
    chk("t6.vld", 32'(out_vld), 0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) push(16'sd6, 1'b0);
    result("t6.fresh", 48, 8, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
